rv_axi_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one single-beat AXI4 master (32-bit data, 40-bit addr)

---
 rtl/rv_axi_pkg.sv | 28 ++
 rtl/rv_axi_arb_rr_arbiter.sv | 44 ++++
 rtl/rv_axi_arb.sv | 218 +++++++++++++++++++++
 tb/tb_rv_axi_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rv_axi_pkg
//  Brief   : Shared types and constants for the rv_axi_arb single-beat AXI4
//            arbiter/sequencer (FSM state encoding, bus widths, burst length).
//  Rev     : 1.0  initial release
// ============================================================================
package rv_axi_pkg;

    typedef logic [2:0] u3_t;

    // Transaction sequencer states
    typedef enum u3_t {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WR_ADDR = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5
    } axi_st_t;

    localparam int         AXI_ADDR_W     = 40;
    localparam int         AXI_DATA_W     = 32;
    // Every transfer is a single beat: AxLEN = 0
    localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;

endpackage : rv_axi_pkg
`default_nettype wire

// File: rtl/rv_axi_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Combinational round-robin pick: first asserted request at or
//            after ptr_i, searching cyclically.
//  Ports   : req_i  [N]   request vector
//            ptr_i  [IW]  highest-priority index for this pick
//            gnt_o  [N]   one-hot winner (0 if no request)
//            idx_o  [IW]  encoded winner (0 if no request)
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin : p_pick
        logic found;
        int   j;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            // Candidate index wraps past N-1 back to 0
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_i[j[IW-1:0]]) begin
                found              = 1'b1;
                gnt_o[j[IW-1:0]]   = 1'b1;
                idx_o              = j[IW-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/rv_axi_arb.sv
`default_nettype none
// ============================================================================
//  Module  : rv_axi_arb
//  Brief   : Round-robin arbiter/sequencer sharing one single-beat AXI4 master
//            (32-bit data, 40-bit address) between NREQ requesters. One
//            outstanding transaction; len=0, wlast=1 always.
//  Ports   : aclk_i / arst_n_i        clock, async active-low reset
//            req_i/we_i/adr_i/dw_i    per-requester access (we==0 -> read)
//            done_o/dr_o/gnt_o        completion pulse, read data, owner
//            aw*/w*/b*/ar*/r*         AXI4 master channels
//  Rev     : 1.0  initial release
// ============================================================================
module rv_axi_arb #(
    parameter int         NREQ  = 2,
    parameter logic [7:0] ABASE = 8'h00
) (
    input  logic               aclk_i,
    input  logic               arst_n_i,
    // requester side
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*4-1:0]  we_i,
    input  logic [NREQ*32-1:0] adr_i,
    input  logic [NREQ*32-1:0] dw_i,
    output logic [NREQ-1:0]    done_o,
    output logic [31:0]        dr_o,
    output logic [NREQ-1:0]    gnt_o,
    // AXI write address
    output logic [39:0]        awaddr_o,
    output logic [7:0]         awlen_o,
    output logic               awvalid_o,
    input  logic               awready_i,
    // AXI write data
    output logic [31:0]        wr_data_o,
    output logic [3:0]         wstrb_o,
    output logic               wlast_o,
    output logic               wvalid_o,
    input  logic               wready_i,
    // AXI write response
    input  logic               bvalid_i,
    output logic               bready_o,
    // AXI read address
    output logic [39:0]        araddr_o,
    output logic [7:0]         arlen_o,
    output logic               arvalid_o,
    input  logic               arready_i,
    // AXI read data
    input  logic [31:0]        rd_data_i,
    input  logic               rvalid_i,
    input  logic               rlast_i,
    output logic               rready_o
);

    import rv_axi_pkg::*;

    localparam int IW = $clog2(NREQ);

    axi_st_t         state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   ptr_d;
    logic [IW-1:0]   owner_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [31:0]     dr_q;
    logic [31:0]     adr_q;
    logic [31:0]     dw_q;
    logic [3:0]      we_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            arvalid_q;
    logic            bready_q;
    logic            rready_q;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic [31:0]     sel_adr;
    logic [31:0]     sel_dw;
    logic [3:0]      sel_we;

    // rlast carries no information for single-beat reads
    logic            unused_rlast;
    assign unused_rlast = rlast_i;

    // The requester completing this cycle still holds req; masking it with
    // done_q keeps it from being re-granted on a stale request.
    assign arb_req = req_i & ~done_q;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req_i (arb_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Priority moves to the requester after the one just served
    assign ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Command fields of the current owner
    always_comb begin
        sel_adr = '0;
        sel_dw  = '0;
        sel_we  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                sel_adr = adr_i[i*32 +: 32];
                sel_dw  = dw_i[i*32 +: 32];
                sel_we  = we_i[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge aclk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            dr_q      <= '0;
            adr_q     <= '0;
            dw_q      <= '0;
            we_q      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            // done and dr are single-cycle pulses
            done_q <= '0;
            dr_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|arb_req) begin
                        gnt_q   <= arb_gnt;
                        owner_q <= arb_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    adr_q <= sel_adr;
                    dw_q  <= sel_dw;
                    we_q  <= sel_we;
                    if (|sel_we) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WR_ADDR;
                    end else begin
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_ADDR;
                    end
                end
                ST_WR_ADDR: begin
                    // AW and W channels complete independently, in any order
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wready_i) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid_i) begin
                        bready_q <= 1'b0;
                        done_q   <= gnt_q;
                        gnt_q    <= '0;
                        ptr_q    <= ptr_d;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid_i) begin
                        dr_q     <= rd_data_i;
                        rready_q <= 1'b0;
                        done_q   <= gnt_q;
                        gnt_q    <= '0;
                        ptr_q    <= ptr_d;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_o    = done_q;
    assign dr_o      = dr_q;
    assign gnt_o     = gnt_q;
    assign awaddr_o  = {ABASE, adr_q};
    assign awlen_o   = AXI_LEN_SINGLE;
    assign awvalid_o = awvalid_q;
    assign wr_data_o = dw_q;
    assign wstrb_o   = we_q;
    assign wlast_o   = 1'b1;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;
    assign araddr_o  = {ABASE, adr_q};
    assign arlen_o   = AXI_LEN_SINGLE;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;

endmodule : rv_axi_arb
`default_nettype wire

// File: tb/tb_rv_axi_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rv_axi_arb
//  Brief   : Directed scoreboard bench for rv_axi_arb (NREQ=3) with a small
//            AXI slave model whose ready/response delays are programmable.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_rv_axi_arb;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b0;
    logic [2:0]  req    = '0;
    logic [11:0] we     = '0;
    logic [95:0] adr    = '0;
    logic [95:0] dw     = '0;
    logic [2:0]  done, gnt;
    logic [31:0] dr, wr_data, rd_data;
    logic [39:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready, arvalid, arready, rvalid, rlast, rready;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    logic [34:0] sb[$];   // {done one-hot, dr}

    // slave model controls
    int ar_stall = 0, aw_stall = 0, w_stall = 0, r_delay = 0, b_delay = 0;
    logic [31:0] rdata = '0;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit r_pend, b_pend, aw_seen, w_seen;

    always #5 clk = ~clk;

    rv_axi_arb #(.NREQ(3), .ABASE(8'h00)) dut (
        .aclk_i (clk),       .arst_n_i (arst_n),
        .req_i  (req),       .we_i     (we),      .adr_i (adr), .dw_i (dw),
        .done_o (done),      .dr_o     (dr),      .gnt_o (gnt),
        .awaddr_o (awaddr),  .awlen_o  (awlen),   .awvalid_o (awvalid), .awready_i (awready),
        .wr_data_o (wr_data),.wstrb_o  (wstrb),   .wlast_o (wlast),     .wvalid_o (wvalid),
        .wready_i (wready),  .bvalid_i (bvalid),  .bready_o (bready),
        .araddr_o (araddr),  .arlen_o  (arlen),   .arvalid_o (arvalid), .arready_i (arready),
        .rd_data_i (rd_data),.rvalid_i (rvalid),  .rlast_i (rlast),     .rready_o (rready)
    );

    // ---------------- AXI slave model ----------------
    assign arready = arvalid && (ar_cnt >= ar_stall);
    assign awready = awvalid && (aw_cnt >= aw_stall);
    assign wready  = wvalid  && (w_cnt  >= w_stall);
    assign rvalid  = r_pend  && (r_cnt  >= r_delay);
    assign bvalid  = b_pend  && (b_cnt  >= b_delay);
    assign rd_data = rvalid ? rdata : 32'h0;
    assign rlast   = rvalid;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
        end else begin
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
            else if (arvalid && arready) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0;
            end
            if (r_pend) begin
                if (rvalid && rready) r_pend <= 1'b0;
                else if (!rvalid) r_cnt <= r_cnt + 1;
            end
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            else if (awvalid && awready) begin aw_cnt <= 0; aw_seen <= 1'b1; end
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            else if (wvalid && wready) begin w_cnt <= 0; w_seen <= 1'b1; end
            if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready)) && !b_pend) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end
            if (b_pend) begin
                if (bvalid && bready) b_pend <= 1'b0;
                else if (!bvalid) b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    task automatic wait_done(input int i, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done[i]) got = 1'b1;
        end
        if (!got) timeout($sformatf("done%0d", i));
    endtask

    task automatic wait_any_done(input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done != 3'b000) got = 1'b1;
        end
        if (!got) timeout("any_done");
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (done != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'h0);
                end else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    chk("sb_done", 64'(done), 64'(e[34:32]));
                    chk("sb_dr",   64'(dr),   64'(e[31:0]));
                end
            end else begin
                chk("dr_zero_off_done", 64'(dr), 64'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt",    64'(gnt),  64'h0);
        chk("rst_done",   64'(done), 64'h0);
        chk("rst_dr",     64'(dr),   64'h0);
        chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'h0);
        chk("rst_lens",   64'({awlen, arlen, wlast}), 64'h1);
        arst_n = 1'b1;
        mon_en = 1'b1;

        // 1: single read, zero-wait slave, latency check
        rdata = 32'hDEAD_BEEF;
        sb.push_back({3'b001, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        req[0] = 1'b1; we[3:0] = 4'h0; adr[31:0] = 32'h0010_0040;
        @(negedge clk); chk("t1_c0_gnt", 64'(gnt), 64'h0);
        @(negedge clk); chk("t1_c1_gnt", 64'(gnt), 64'h1);
        @(negedge clk);
        chk("t1_c2_arvalid", 64'(arvalid), 64'h1);
        chk("t1_c2_araddr",  64'(araddr),  64'h00_0010_0040);
        chk("t1_c2_arlen",   64'(arlen),   64'h0);
        @(negedge clk); chk("t1_c3_rready", 64'(rready), 64'h1);
        @(negedge clk); chk("t1_c4_done",   64'(done),   64'h1);
        @(posedge clk); #1 req[0] = 1'b0;

        // 2: write with 3-cycle AW stall, delayed B
        aw_stall = 3; b_delay = 2;
        sb.push_back({3'b010, 32'h0});
        @(posedge clk); #1;
        req[1] = 1'b1; we[7:4] = 4'b0011; dw[63:32] = 32'h1234_5678; adr[63:32] = 32'h2000_0008;
        @(negedge clk);
        @(negedge clk); chk("t2_c1_gnt", 64'(gnt), 64'h2);
        @(negedge clk);
        chk("t2_c2_valids", 64'({awvalid, wvalid}), 64'h3);
        chk("t2_c2_awaddr", 64'(awaddr),  64'h00_2000_0008);
        chk("t2_c2_wstrb",  64'(wstrb),   64'h3);
        chk("t2_c2_wdata",  64'(wr_data), 64'h1234_5678);
        chk("t2_c2_wlast",  64'({wlast, awlen}), 64'h100);
        @(negedge clk); chk("t2_c3_valids", 64'({awvalid, wvalid}), 64'h2);
        @(negedge clk); chk("t2_c4_aw_br",  64'({awvalid, bready}), 64'h2);
        @(negedge clk); chk("t2_c5_awvalid", 64'(awvalid), 64'h1);
        @(negedge clk); chk("t2_c6_aw_br_done", 64'({awvalid, bready, done}), 64'h08);
        @(negedge clk); chk("t2_c7_br_done",    64'({bready, done}), 64'h8);
        wait_done(1, 20);
        @(posedge clk); #1 req[1] = 1'b0;
        aw_stall = 0; b_delay = 0;

        // 4: arvalid/araddr held while arready low for 10 cycles
        ar_stall = 10; rdata = 32'h0BAD_F00D;
        sb.push_back({3'b100, 32'h0BAD_F00D});
        @(posedge clk); #1;
        req[2] = 1'b1; we[11:8] = 4'h0; adr[95:64] = 32'h3000_0100;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (arvalid) seen = 1'b1;
            end
            if (!seen) timeout("t4_arvalid");
        end
        for (int k = 0; k < 10; k++) begin
            chk("t4_hold_arvalid", 64'(arvalid), 64'h1);
            chk("t4_hold_araddr",  64'(araddr),  64'h00_3000_0100);
            chk("t4_hold_nodone",  64'(done),    64'h0);
            if (k < 9) @(negedge clk);
        end
        wait_done(2, 20);
        @(posedge clk); #1 req[2] = 1'b0;
        ar_stall = 0;

        // 3: fairness, all three requesting reads for nine transactions
        rdata = 32'hCAFE_0001;
        for (int n = 0; n < 9; n++) sb.push_back({3'(1 << (n % 3)), 32'hCAFE_0001});
        @(posedge clk); #1;
        we = '0; adr = {32'h3000_0200, 32'h2000_0200, 32'h1000_0200};
        req = 3'b111;
        for (int n = 0; n < 9; n++) begin
            wait_any_done(30);
            if (n == 7) begin @(posedge clk); #1 req[1:0] = 2'b00; end
            if (n == 8) begin @(posedge clk); #1 req = 3'b000; end
        end

        // 6: requester 1 drops req right after grant; write still completes
        sb.push_back({3'b010, 32'h0});
        @(posedge clk); #1;
        req[1] = 1'b1; we[7:4] = 4'hF; dw[63:32] = 32'hA5A5_5A5A; adr[63:32] = 32'h2000_0010;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (gnt[1]) seen = 1'b1;
            end
            if (!seen) timeout("t6_gnt");
        end
        @(posedge clk); #1 req[1] = 1'b0;
        @(negedge clk);
        chk("t6_awvalid", 64'(awvalid), 64'h1);
        chk("t6_wdata",   64'(wr_data), 64'hA5A5_5A5A);
        wait_done(1, 20);
        repeat (8) @(negedge clk);

        // 5: reset while waiting in RdData, then reissue
        r_delay = 20;
        @(posedge clk); #1;
        req[0] = 1'b1; we[3:0] = 4'h0; adr[31:0] = 32'h0010_0080;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (rready) seen = 1'b1;
            end
            if (!seen) timeout("t5_rready");
        end
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        chk("t5_rst_rready", 64'(rready), 64'h0);
        chk("t5_rst_gnt",    64'(gnt),    64'h0);
        chk("t5_rst_done",   64'(done),   64'h0);
        chk("t5_rst_valids", 64'({awvalid, wvalid, arvalid, bready}), 64'h0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        r_delay = 0; rdata = 32'h1357_9BDF;
        sb.push_back({3'b001, 32'h1357_9BDF});
        @(posedge clk); #1 req[0] = 1'b1;
        wait_done(0, 20);
        @(posedge clk); #1 req[0] = 1'b0;

        repeat (10) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rv_axi_arb
`default_nettype wire
